ecc_cmd_issuer: RTL and testbench
=================================

// Module: ecc_cmd_issuer
// PURPOSE
//  Core-side initiator for the ECC coprocessor's CV-X-IF issue/result channel.
//  - Accepts one modular-arithmetic command at a time (MOD/ADD/SUB/MUL/INV).
//  - Encodes each command into an x_issue_req_t, issues it, and waits for the single x_result.
//  - Returns the result to the requester through a valid/ready response port.
//  - Sits between the core's command source and the ECC accelerator; at most one transaction is outstanding.
// PARAMETERS
//  OPCODE      7'b1111011  major opcode placed in instr[6:0] (custom-3)
//  TIMEOUT     1024        max cycles in WAIT_RES before an error response; >=2
// PORTS
//  clk_i            in   1        clock, all logic on rising edge
//  rst_i            in   1        reset, synchronous, active-high
//  cmd_valid_i      in   1        command offered
//  cmd_ready_o      out  1        command accepted when valid&ready
//  cmd_funct3_i     in   3        000 MOD, 001 ADD, 010 SUB, 011 MUL, 100 INV
//  cmd_rd_i         in   5        destination register tag
//  cmd_rs1_i        in   64       operand a (modulus for MOD)
//  cmd_rs2_i        in   64       operand b (ignored for MOD/INV)
//  x_issue_valid_o  out  1        issue request valid
//  x_issue_req_o    out  x_issue_req_t  issue payload
//  x_issue_ready_i  in   1        coprocessor ready; transfer = valid&ready
//  x_result_valid_i in   1        one-cycle result pulse from coprocessor
//  x_result_i       in   x_result_t  result payload (id, data, rd, we, exc)
//  rsp_valid_o      out  1        response valid
//  rsp_ready_i      in   1        response consumed when valid&ready
//  rsp_data_o       out  64       result data
//  rsp_rd_o         out  5        echoed rd
//  rsp_we_o         out  1        echoed x_result.we
//  rsp_err_o        out  1        timeout occurred, or exc set in the result
// BEHAVIOUR
//  Reset (rst_i high at a clock edge)
//   - State goes to IDLE.
//   - All outputs go to 0 except cmd_ready_o, which is 1 in IDLE.
//   - id counter goes to 0. The timeout counter goes to 0.
//   - Reset mid-operation abandons the transaction; no response is produced.
//  Payload encoding
//   - instr = {7'b0, 5'd2, 5'd1, funct3, rd, OPCODE}.
//   - rs[0] = rs1, rs[1] = rs2. rs_valid = all ones. mode = 0. id = id counter.
//  Latency
//   - Command accepted in cycle N -> x_issue_valid_o is 1 from cycle N+1.
//   - Result pulse seen in cycle M -> rsp_valid_o is 1 from cycle M+1.
//  States
//   - IDLE
//     - cmd_ready_o = 1.
//     - On cmd_valid_i: latch the payload, go to ISSUE.
//   - ISSUE
//     - x_issue_valid_o = 1; payload held stable.
//     - On x_issue_ready_i: go to WAIT_RES and clear the timeout counter.
//     - No timeout is applied in ISSUE.
//   - WAIT_RES
//     - On x_result_valid_i with x_result_i.id == the outstanding id:
//       capture data/rd/we, set rsp_err_o = exc, go to RESP.
//     - A result pulse with a different id is ignored.
//     - If the timeout counter reaches TIMEOUT-1 with no matching result:
//       go to RESP with data=0, we=0, err=1.
//     - A matching result and timeout in the same cycle: the result wins.
//   - RESP
//     - rsp_valid_o = 1; outputs held stable until rsp_ready_i.
//     - On rsp_ready_i: increment the id counter, go to IDLE.
//     - A result pulse arriving in RESP or IDLE is dropped.
//  Timing and counters
//   - cmd_ready_o is 0 outside IDLE; no command is accepted in the same cycle a response retires.
//   - id counter: X_ID_WIDTH bits, wraps from all-ones to 0.
//   - funct3 values 101..111 are issued unchanged; the coprocessor ignores them, so these commands end in a timeout response.
// STRUCTURE
//  - cvxif_pkg: x_issue_req_t, x_result_t, X_ID_WIDTH.
//  - New shared ecc_pkg:
//    - funct3 constants ECC_F3_MOD/ADD/SUB/MUL/INV.
//    - ECC_OPCODE.
//    - issuer state enum {IDLE, ISSUE, WAIT_RES, RESP}.
//  - Single module, no sub-modules; the timeout counter is inline.
// TESTING (bench provides a mock responder with programmable delay)
//  1 ADD rs1=5 rs2=7 rd=10, mock returns data=12 after 3 cycles
//    -> rsp_data=12, rsp_rd=10, rsp_we=1, rsp_err=0; instr[14:12]=001.
//  2 MOD rs1=0x61, mock pulses we=0 -> rsp_we=0, rsp_err=0;
//    x_issue_req_o.rs[0]=0x61.
//  3 x_issue_ready_i held low 20 cycles -> x_issue_valid_o stays 1 with a
//    stable payload, no timeout, cmd_ready_o=0 throughout.
//  4 TIMEOUT=16, mock never responds -> rsp_valid=1 exactly 17 cycles
//    after issue, rsp_err=1, rsp_data=0.
//  5 Mock returns a wrong id, then the right id -> the first pulse is ignored and
//    the response carries the second; hold rsp_ready_i low 5 cycles -> outputs stable.
//  6 2^X_ID_WIDTH+1 back-to-back commands -> ids wrap to 0;
//    assert rst_i in WAIT_RES -> next cycle IDLE, cmd_ready_o=1, no rsp_valid.

Source files
------------

// File: rtl/cvxif_pkg.sv
// CV-X-IF issue/result channel types shared by core-side initiators and coprocessors.
package cvxif_pkg;
  localparam int X_ID_WIDTH  = 4;
  localparam int X_RFR_WIDTH = 64;
  localparam int X_NUM_RS    = 2;

  typedef struct packed {
    logic [31:0]                           instr;
    logic [1:0]                            mode;
    logic [X_ID_WIDTH-1:0]                 id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]  rs;
    logic [X_NUM_RS-1:0]                   rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFR_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   exc;
  } x_result_t;
endpackage

// File: rtl/ecc_pkg.sv
// ECC coprocessor command encoding and issuer state shared across the ECC slice.
package ecc_pkg;
  localparam logic [6:0] ECC_OPCODE = 7'b1111011;

  localparam logic [2:0] ECC_F3_MOD = 3'b000;
  localparam logic [2:0] ECC_F3_ADD = 3'b001;
  localparam logic [2:0] ECC_F3_SUB = 3'b010;
  localparam logic [2:0] ECC_F3_MUL = 3'b011;
  localparam logic [2:0] ECC_F3_INV = 3'b100;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, RESP} issuer_state_e;
endpackage

// File: rtl/ecc_cmd_issuer.sv
// Single-outstanding CV-X-IF initiator for ECC commands: issue 1 cycle after accept, response 1 cycle
// after the matching result; issue stalls on x_issue_ready_i, response holds until rsp_ready_i.
module ecc_cmd_issuer
  import cvxif_pkg::*;
  import ecc_pkg::*;
#(
  parameter logic [6:0]  OPCODE  = ECC_OPCODE,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [2:0]   cmd_funct3_i,
  input  logic [4:0]   cmd_rd_i,
  input  logic [63:0]  cmd_rs1_i,
  input  logic [63:0]  cmd_rs2_i,
  output logic         x_issue_valid_o,
  output x_issue_req_t x_issue_req_o,
  input  logic         x_issue_ready_i,
  input  logic         x_result_valid_i,
  input  x_result_t    x_result_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [63:0]  rsp_data_o,
  output logic [4:0]   rsp_rd_o,
  output logic         rsp_we_o,
  output logic         rsp_err_o
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  issuer_state_e         state_q, state_d;
  x_issue_req_t          req_q;
  logic [X_ID_WIDTH-1:0] id_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [63:0]           rsp_data_q;
  logic [4:0]            rsp_rd_q;
  logic                  rsp_we_q;
  logic                  rsp_err_q;

  logic res_match;
  logic timeout_hit;

  assign res_match   = x_result_valid_i && (x_result_i.id == req_q.id);
  assign timeout_hit = (cnt_q == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cmd_valid_i) state_d = ISSUE;
      ISSUE:    if (x_issue_ready_i) state_d = WAIT_RES;
      WAIT_RES: if (res_match || timeout_hit) state_d = RESP;
      RESP:     if (rsp_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o     = (state_q == IDLE);
    x_issue_valid_o = (state_q == ISSUE);
    rsp_valid_o     = (state_q == RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q      <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_rd_q   <= '0;
      rsp_we_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && cmd_valid_i) begin
        req_q.instr    <= {7'b0, 5'd2, 5'd1, cmd_funct3_i, cmd_rd_i, OPCODE};
        req_q.mode     <= 2'b00;
        req_q.id       <= id_q;
        req_q.rs       <= {cmd_rs2_i, cmd_rs1_i};
        req_q.rs_valid <= '1;
      end

      // The counter only runs while a result is awaited; ISSUE may stall indefinitely.
      if (state_q == ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == WAIT_RES && !timeout_hit) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (state_q == WAIT_RES) begin
        if (res_match) begin
          rsp_data_q <= x_result_i.data;
          rsp_rd_q   <= x_result_i.rd;
          rsp_we_q   <= x_result_i.we;
          rsp_err_q  <= x_result_i.exc;
        end else if (timeout_hit) begin
          rsp_data_q <= '0;
          rsp_rd_q   <= req_q.instr[11:7];
          rsp_we_q   <= 1'b0;
          rsp_err_q  <= 1'b1;
        end
      end

      if (state_q == RESP && rsp_ready_i) id_q <= id_q + 1'b1;
    end
  end

  assign x_issue_req_o = req_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_rd_o      = rsp_rd_q;
  assign rsp_we_o      = rsp_we_q;
  assign rsp_err_o     = rsp_err_q;

endmodule

// File: tb/tb_ecc_cmd_issuer.sv
// Directed bench for ecc_cmd_issuer with an inline mock coprocessor responder.
module tb_ecc_cmd_issuer;
  import cvxif_pkg::*;
  import ecc_pkg::*;

  logic         clk = 1'b0;
  logic         rst_i = 1'b0;
  logic         cmd_valid_i = 1'b0;
  logic         cmd_ready_o;
  logic [2:0]   cmd_funct3_i = '0;
  logic [4:0]   cmd_rd_i = '0;
  logic [63:0]  cmd_rs1_i = '0;
  logic [63:0]  cmd_rs2_i = '0;
  logic         x_issue_valid_o;
  x_issue_req_t x_issue_req_o;
  logic         x_issue_ready_i = 1'b0;
  logic         x_result_valid_i = 1'b0;
  x_result_t    x_result_i = '0;
  logic         rsp_valid_o;
  logic         rsp_ready_i = 1'b0;
  logic [63:0]  rsp_data_o;
  logic [4:0]   rsp_rd_o;
  logic         rsp_we_o;
  logic         rsp_err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ecc_cmd_issuer #(.OPCODE(7'b1111011), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_funct3_i(cmd_funct3_i),
    .cmd_rd_i(cmd_rd_i), .cmd_rs1_i(cmd_rs1_i), .cmd_rs2_i(cmd_rs2_i),
    .x_issue_valid_o(x_issue_valid_o), .x_issue_req_o(x_issue_req_o), .x_issue_ready_i(x_issue_ready_i),
    .x_result_valid_i(x_result_valid_i), .x_result_i(x_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_rd_o(rsp_rd_o), .rsp_we_o(rsp_we_o), .rsp_err_o(rsp_err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] f3, input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b);
    cmd_valid_i = 1'b1; cmd_funct3_i = f3; cmd_rd_i = rd; cmd_rs1_i = a; cmd_rs2_i = b;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic do_issue();
    x_issue_ready_i = 1'b1;
    tick();
    x_issue_ready_i = 1'b0;
  endtask

  task automatic pulse(input logic [X_ID_WIDTH-1:0] id, input logic [63:0] data, input logic [4:0] rd,
                       input logic we, input logic exc, input int delay);
    repeat (delay) tick();
    x_result_valid_i = 1'b1;
    x_result_i = '{id: id, data: data, rd: rd, we: we, exc: exc};
    tick();
    x_result_valid_i = 1'b0;
  endtask

  task automatic retire();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%0b exp=1", cmd_ready_o); end
    total++; if (x_issue_valid_o !== 1'b0) begin bad++; $display("FAIL rst_issue_valid got=%0b exp=0", x_issue_valid_o); end
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%0b exp=0", rsp_valid_o); end
    total++; if (x_issue_req_o !== '0) begin bad++; $display("FAIL rst_issue_req got=%0h exp=0", x_issue_req_o); end
    total++; if ({rsp_data_o, rsp_rd_o, rsp_we_o, rsp_err_o} !== '0) begin bad++; $display("FAIL rst_rsp_fields got=%0h exp=0", {rsp_data_o, rsp_rd_o, rsp_we_o, rsp_err_o}); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_add();
    send_cmd(ECC_F3_ADD, 5'd10, 64'd5, 64'd7);
    total++; if (x_issue_valid_o !== 1'b1) begin bad++; $display("FAIL add_issue_valid got=%0b exp=1", x_issue_valid_o); end
    total++; if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL add_cmd_ready got=%0b exp=0", cmd_ready_o); end
    total++; if (x_issue_req_o.instr[14:12] !== 3'b001) begin bad++; $display("FAIL add_funct3 got=%0b exp=001", x_issue_req_o.instr[14:12]); end
    total++; if (x_issue_req_o.instr !== 32'h0020_957B) begin bad++; $display("FAIL add_instr got=%0h exp=20957b", x_issue_req_o.instr); end
    total++; if (x_issue_req_o.id !== 4'd0) begin bad++; $display("FAIL add_id got=%0d exp=0", x_issue_req_o.id); end
    total++; if (x_issue_req_o.rs[1] !== 64'd7 || x_issue_req_o.rs_valid !== 2'b11 || x_issue_req_o.mode !== 2'b00) begin
      bad++; $display("FAIL add_rs_fields got rs1=%0h rsv=%0b mode=%0b exp rs1=7 rsv=11 mode=0", x_issue_req_o.rs[1], x_issue_req_o.rs_valid, x_issue_req_o.mode); end
    do_issue();
    total++; if (x_issue_valid_o !== 1'b0) begin bad++; $display("FAIL add_issue_drop got=%0b exp=0", x_issue_valid_o); end
    pulse(4'd0, 64'd12, 5'd10, 1'b1, 1'b0, 3);
    total++; if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL add_rsp_valid got=%0b exp=1", rsp_valid_o); end
    total++; if (rsp_data_o !== 64'd12 || rsp_rd_o !== 5'd10 || rsp_we_o !== 1'b1 || rsp_err_o !== 1'b0) begin
      bad++; $display("FAIL add_rsp got data=%0d rd=%0d we=%0b err=%0b exp 12/10/1/0", rsp_data_o, rsp_rd_o, rsp_we_o, rsp_err_o); end
    retire();
    total++; if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin bad++; $display("FAIL add_retire got valid=%0b ready=%0b exp 0/1", rsp_valid_o, cmd_ready_o); end
  endtask

  task automatic test_mod();
    send_cmd(ECC_F3_MOD, 5'd3, 64'h61, 64'hDEAD);
    total++; if (x_issue_req_o.rs[0] !== 64'h61) begin bad++; $display("FAIL mod_rs0 got=%0h exp=61", x_issue_req_o.rs[0]); end
    total++; if (x_issue_req_o.instr[14:12] !== 3'b000 || x_issue_req_o.id !== 4'd1) begin
      bad++; $display("FAIL mod_f3_id got f3=%0b id=%0d exp 000/1", x_issue_req_o.instr[14:12], x_issue_req_o.id); end
    do_issue();
    pulse(4'd1, 64'h5, 5'd3, 1'b0, 1'b0, 1);
    total++; if (rsp_valid_o !== 1'b1 || rsp_we_o !== 1'b0 || rsp_err_o !== 1'b0 || rsp_data_o !== 64'h5) begin
      bad++; $display("FAIL mod_rsp got valid=%0b we=%0b err=%0b data=%0h exp 1/0/0/5", rsp_valid_o, rsp_we_o, rsp_err_o, rsp_data_o); end
    retire();
  endtask

  task automatic test_issue_stall();
    int errs = 0;
    send_cmd(ECC_F3_MUL, 5'd7, 64'h1111, 64'h2222);
    for (int i = 0; i < 20; i++) begin
      total++;
      if (x_issue_valid_o !== 1'b1 || cmd_ready_o !== 1'b0 || rsp_valid_o !== 1'b0 ||
          x_issue_req_o.instr !== 32'h0020_B3FB || x_issue_req_o.id !== 4'd2 ||
          x_issue_req_o.rs[0] !== 64'h1111 || x_issue_req_o.rs[1] !== 64'h2222) begin
        bad++; errs++;
        if (errs < 4) $display("FAIL stall_cycle%0d got valid=%0b ready=%0b rsp=%0b instr=%0h id=%0d exp 1/0/0/20b3fb/2",
                               i, x_issue_valid_o, cmd_ready_o, rsp_valid_o, x_issue_req_o.instr, x_issue_req_o.id);
      end
      tick();
    end
    do_issue();
    pulse(4'd2, 64'h4444, 5'd7, 1'b1, 1'b0, 0);
    total++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 64'h4444 || rsp_err_o !== 1'b0) begin
      bad++; $display("FAIL stall_rsp got valid=%0b data=%0h err=%0b exp 1/4444/0", rsp_valid_o, rsp_data_o, rsp_err_o); end
    retire();
  endtask

  task automatic test_timeout();
    int early = 0;
    send_cmd(ECC_F3_INV, 5'd4, 64'h99, 64'h0);
    do_issue();
    for (int i = 0; i < 16; i++) begin
      if (rsp_valid_o !== 1'b0) early++;
      tick();
    end
    total++; if (early != 0) begin bad++; $display("FAIL tmo_early got=%0d early cycles exp=0", early); end
    total++; if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL tmo_valid got=%0b exp=1", rsp_valid_o); end
    total++; if (rsp_err_o !== 1'b1 || rsp_data_o !== 64'd0 || rsp_we_o !== 1'b0) begin
      bad++; $display("FAIL tmo_fields got err=%0b data=%0h we=%0b exp 1/0/0", rsp_err_o, rsp_data_o, rsp_we_o); end
    retire();
  endtask

  task automatic test_wrong_id();
    int errs = 0;
    send_cmd(ECC_F3_SUB, 5'd9, 64'd10, 64'd3);
    do_issue();
    pulse(4'd9, 64'd99, 5'd9, 1'b1, 1'b0, 1);
    total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL wid_ignored got=%0b exp=0", rsp_valid_o); end
    pulse(4'd4, 64'h33, 5'd9, 1'b1, 1'b1, 2);
    total++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 64'h33 || rsp_err_o !== 1'b1 || rsp_rd_o !== 5'd9) begin
      bad++; $display("FAIL wid_rsp got valid=%0b data=%0h err=%0b rd=%0d exp 1/33/1/9", rsp_valid_o, rsp_data_o, rsp_err_o, rsp_rd_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== 64'h33 || rsp_err_o !== 1'b1 || rsp_we_o !== 1'b1 || rsp_rd_o !== 5'd9) begin
        bad++; errs++;
        if (errs < 3) $display("FAIL wid_hold%0d got valid=%0b data=%0h err=%0b exp 1/33/1", i, rsp_valid_o, rsp_data_o, rsp_err_o);
      end
    end
    retire();
  endtask

  task automatic test_id_wrap();
    logic [X_ID_WIDTH-1:0] exp_id;
    logic [63:0] exp_data;
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    exp_id = '0;
    for (int i = 0; i < (1 << X_ID_WIDTH) + 1; i++) begin
      exp_data = 64'(i + 100);
      send_cmd(ECC_F3_ADD, 5'(i), 64'(i), 64'd1);
      total++; if (x_issue_req_o.id !== exp_id) begin bad++; $display("FAIL wrap_id%0d got=%0d exp=%0d", i, x_issue_req_o.id, exp_id); end
      do_issue();
      pulse(exp_id, exp_data, 5'(i), 1'b1, 1'b0, 0);
      total++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== exp_data) begin
        bad++; $display("FAIL wrap_rsp%0d got valid=%0b data=%0d exp 1/%0d", i, rsp_valid_o, rsp_data_o, exp_data); end
      retire();
      exp_id = exp_id + 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    send_cmd(ECC_F3_MUL, 5'd2, 64'd6, 64'd7);
    do_issue();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    total++; if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || x_issue_valid_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_state got ready=%0b rsp=%0b issue=%0b exp 1/0/0", cmd_ready_o, rsp_valid_o, x_issue_valid_o); end
    pulse(4'd1, 64'd42, 5'd2, 1'b1, 1'b0, 0);
    total++; if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      bad++; $display("FAIL rstmid_drop got rsp=%0b ready=%0b exp 0/1", rsp_valid_o, cmd_ready_o); end
    send_cmd(ECC_F3_ADD, 5'd1, 64'd1, 64'd1);
    total++; if (x_issue_req_o.id !== 4'd0) begin bad++; $display("FAIL rstmid_id got=%0d exp=0", x_issue_req_o.id); end
    do_issue();
    pulse(4'd0, 64'd2, 5'd1, 1'b1, 1'b0, 0);
    total++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 64'd2) begin
      bad++; $display("FAIL rstmid_after got valid=%0b data=%0d exp 1/2", rsp_valid_o, rsp_data_o); end
    retire();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mod();
    test_issue_stall();
    test_timeout();
    test_wrong_id();
    test_id_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
